// File: rtl/cpu_program_sequencer_pkg.sv
// Shared definitions for the program sequencer: CPU opcodes, the program
// word layout and the sequencer state encoding.
package cpu_program_sequencer_pkg;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned WORD_W = OP_W + 2 * NIB_W;

  typedef logic [OP_W-1:0] opcode_t;

  // CPU opcodes
  localparam opcode_t OP_ADD   = 4'b0000;
  localparam opcode_t OP_SUB   = 4'b0001;
  localparam opcode_t OP_STORE = 4'b0010;
  localparam opcode_t OP_LOAD  = 4'b0011;
  localparam opcode_t OP_AND   = 4'b0101;
  localparam opcode_t OP_OR    = 4'b0110;
  localparam opcode_t OP_XOR   = 4'b0111;
  localparam opcode_t OP_SHL   = 4'b1001;
  localparam opcode_t OP_SHR   = 4'b1010;
  // Sequencer-only stop marker, never driven to the CPU
  localparam opcode_t OP_HALT  = 4'hE;
  // Not decoded by the CPU, keeps its FSM idle
  localparam opcode_t OP_IDLE  = 4'hF;

  typedef struct packed {
    opcode_t            opcode;
    logic [NIB_W-1:0]   addr;
    logic [NIB_W-1:0]   data;
  } prog_word_t;

  localparam prog_word_t HALT_WORD = '{opcode: OP_HALT, addr: 4'h0, data: 4'h0};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_ISSUE   = 3'd2,
    S_WAIT    = 3'd3,
    S_CAPTURE = 3'd4,
    S_DONE    = 3'd5
  } seq_state_t;

  function automatic logic is_store(input opcode_t op);
    return op == OP_STORE;
  endfunction

endpackage

// File: rtl/cpu_program_sequencer_if.sv
// CPU pin bus between the sequencer (master) and the accumulator CPU (slave).
//   cpu_opcode/cpu_addr/cpu_data/cpu_write_enable : instruction pins to CPU
//   cpu_acc_in                                    : CPU accumulator back
interface cpu_program_sequencer_if;
  import cpu_program_sequencer_pkg::*;

  opcode_t          cpu_opcode;
  logic [NIB_W-1:0] cpu_addr;
  logic [NIB_W-1:0] cpu_data;
  logic             cpu_write_enable;
  logic [NIB_W-1:0] cpu_acc_in;

  modport master (
    output cpu_opcode, cpu_addr, cpu_data, cpu_write_enable,
    input  cpu_acc_in
  );

  modport slave (
    input  cpu_opcode, cpu_addr, cpu_data, cpu_write_enable,
    output cpu_acc_in
  );

endinterface

// File: rtl/cpu_program_mem.sv
// Program store: DEPTH x 12 register file, reset clears every word to HALT.
//   clk, rst      : clock, synchronous active-high reset
//   we/waddr/wdata: synchronous write port
//   raddr/rdata   : registered read port; a same-cycle write to raddr is
//                   forwarded so the next read sees the new word
module cpu_program_mem
  import cpu_program_sequencer_pkg::*;
#(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  prog_word_t    wdata,
  input  logic [AW-1:0] raddr,
  output prog_word_t    rdata
);

  prog_word_t mem_q [DEPTH];
  prog_word_t rdata_d;
  prog_word_t rdata_q;

  // Read with write-forwarding
  always_comb begin
    rdata_d = mem_q[raddr];
    if (we && (waddr == raddr)) rdata_d = wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[AW'(i)] <= HALT_WORD;
      rdata_q <= HALT_WORD;
    end else begin
      if (we) mem_q[waddr] <= wdata;
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/cpu_program_sequencer.sv
// Self-running instruction issuer for the 4-bit accumulator CPU.
//   clk, rst                      : clock, synchronous active-high reset
//   prog_we/prog_addr/prog_word   : program load port (IDLE only)
//   start, abort                  : launch from pc 0 / stop immediately
//   cpu_bus (master)              : CPU opcode/addr/data/we pins, acc in
//   result, result_valid          : sampled accumulator and its pulse
//   pc, busy, done                : program counter, running, completion pulse
module cpu_program_sequencer
  import cpu_program_sequencer_pkg::*;
#(
  parameter  int unsigned PROG_DEPTH    = 16,
  parameter  int unsigned ISSUE_CYCLES  = 3,
  parameter  int unsigned SETTLE_CYCLES = 2,
  localparam int unsigned PC_W          = $clog2(PROG_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    prog_we,
  input  logic [PC_W-1:0]         prog_addr,
  input  logic [WORD_W-1:0]       prog_word,
  input  logic                    start,
  input  logic                    abort,
  cpu_program_sequencer_if.master cpu_bus,
  output logic [NIB_W-1:0]        result,
  output logic                    result_valid,
  output logic [PC_W-1:0]         pc,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned CNT_MAX = (ISSUE_CYCLES > SETTLE_CYCLES) ? ISSUE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  seq_state_t       state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  opcode_t          instr_op_q, instr_op_d;
  logic [NIB_W-1:0] result_q, result_d;
  logic             result_valid_q, result_valid_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  opcode_t          cpu_opcode_q, cpu_opcode_d;
  logic             cpu_we_q, cpu_we_d;
  logic [NIB_W-1:0] cpu_addr_q, cpu_addr_d;
  logic [NIB_W-1:0] cpu_data_q, cpu_data_d;
  logic             mem_we;
  prog_word_t       mem_rdata;

  // Read address follows the next pc so the word is ready during FETCH
  cpu_program_mem #(.DEPTH(PROG_DEPTH)) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .waddr (prog_addr),
    .wdata (prog_word_t'(prog_word)),
    .raddr (pc_d),
    .rdata (mem_rdata)
  );

  // Next-state and next-output logic; *_d values are what the pins show next cycle
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    cnt_d          = cnt_q;
    instr_op_d     = instr_op_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    done_d         = 1'b0;
    cpu_opcode_d   = OP_IDLE;
    cpu_we_d       = 1'b0;
    cpu_addr_d     = cpu_addr_q;
    cpu_data_d     = cpu_data_q;
    mem_we         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cpu_addr_d = '0;
        cpu_data_d = '0;
        mem_we     = prog_we;
        if (start && !abort) begin
          pc_d    = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        instr_op_d = mem_rdata.opcode;
        if (mem_rdata.opcode == OP_HALT) begin
          state_d    = S_DONE;
          done_d     = 1'b1;
          cpu_addr_d = '0;
          cpu_data_d = '0;
        end else begin
          state_d      = S_ISSUE;
          cnt_d        = CNT_W'(ISSUE_CYCLES - 1);
          cpu_opcode_d = mem_rdata.opcode;
          cpu_addr_d   = mem_rdata.addr;
          cpu_data_d   = mem_rdata.data;
          cpu_we_d     = is_store(mem_rdata.opcode);
        end
      end
      S_ISSUE: begin
        if (cnt_q == '0) begin
          state_d = S_WAIT;
          cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
        end else begin
          cnt_d        = cnt_q - CNT_W'(1);
          cpu_opcode_d = instr_op_q;
          cpu_we_d     = is_store(instr_op_q);
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d        = S_CAPTURE;
          result_d       = cpu_bus.cpu_acc_in;
          result_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_CAPTURE: begin
        if (pc_q == PC_W'(PROG_DEPTH - 1)) begin
          state_d    = S_DONE;
          done_d     = 1'b1;
          cpu_addr_d = '0;
          cpu_data_d = '0;
        end else begin
          pc_d    = pc_q + PC_W'(1);
          state_d = S_FETCH;
        end
      end
      S_DONE: begin
        state_d    = S_IDLE;
        cpu_addr_d = '0;
        cpu_data_d = '0;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over every transition; pc and result are held
    if (abort && (state_q != S_IDLE)) begin
      state_d        = S_IDLE;
      pc_d           = pc_q;
      cnt_d          = cnt_q;
      result_d       = result_q;
      result_valid_d = 1'b0;
      done_d         = 1'b0;
      cpu_opcode_d   = OP_IDLE;
      cpu_we_d       = 1'b0;
      cpu_addr_d     = '0;
      cpu_data_d     = '0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      pc_q           <= '0;
      cnt_q          <= '0;
      instr_op_q     <= OP_HALT;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      done_q         <= 1'b0;
      busy_q         <= 1'b0;
      cpu_opcode_q   <= OP_IDLE;
      cpu_we_q       <= 1'b0;
      cpu_addr_q     <= '0;
      cpu_data_q     <= '0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      cnt_q          <= cnt_d;
      instr_op_q     <= instr_op_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      done_q         <= done_d;
      busy_q         <= busy_d;
      cpu_opcode_q   <= cpu_opcode_d;
      cpu_we_q       <= cpu_we_d;
      cpu_addr_q     <= cpu_addr_d;
      cpu_data_q     <= cpu_data_d;
    end
  end

  assign cpu_bus.cpu_opcode       = cpu_opcode_q;
  assign cpu_bus.cpu_addr         = cpu_addr_q;
  assign cpu_bus.cpu_data         = cpu_data_q;
  assign cpu_bus.cpu_write_enable = cpu_we_q;
  assign result                   = result_q;
  assign result_valid             = result_valid_q;
  assign pc                       = pc_q;
  assign busy                     = busy_q;
  assign done                     = done_q;

endmodule

// File: tb/tb_cpu_program_sequencer.sv
// Directed bench for cpu_program_sequencer with a tiny accumulator CPU model
// and a result scoreboard.
module tb_cpu_program_sequencer;
  import cpu_program_sequencer_pkg::*;

  typedef struct packed {
    logic [3:0] res;
    logic [3:0] pc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [11:0] prog_word;
  logic        start;
  logic        abort;
  logic [3:0]  result;
  logic        result_valid;
  logic [3:0]  pc;
  logic        busy;
  logic        done;

  cpu_program_sequencer_if bus ();

  cpu_program_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .prog_we      (prog_we),
    .prog_addr    (prog_addr),
    .prog_word    (prog_word),
    .start        (start),
    .abort        (abort),
    .cpu_bus      (bus),
    .result       (result),
    .result_valid (result_valid),
    .pc           (pc),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   done_cnt    = 0;
  int   we_cnt      = 0;
  int   rv_cyc[$];
  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Accumulator CPU model: executes once on the first cycle an opcode appears
  logic [3:0] acc;
  logic [3:0] ram [16];
  opcode_t    prev_op;
  assign bus.cpu_acc_in = acc;

  always @(posedge clk) begin
    if (rst) begin
      acc     <= 4'h0;
      prev_op <= OP_IDLE;
      for (int i = 0; i < 16; i++) ram[i[3:0]] <= (i == 5) ? 4'h2 : 4'h0;
    end else begin
      prev_op <= bus.cpu_opcode;
      if (bus.cpu_opcode != OP_IDLE && prev_op == OP_IDLE) begin
        case (bus.cpu_opcode)
          OP_LOAD:  acc <= ram[bus.cpu_addr];
          OP_ADD:   acc <= acc + bus.cpu_data;
          OP_STORE: ram[bus.cpu_addr] <= acc;
          default:  ;
        endcase
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard / pin monitors
  always @(negedge clk) begin
    exp_t e;
    if (!rst && result_valid) begin
      rv_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        check("unexpected_result_valid", 32'(result_valid), 32'(0));
      end else begin
        e = sb.pop_front();
        check("result", 32'(result), 32'(e.res));
        check("result_pc", 32'(pc), 32'(e.pc));
      end
    end
    if (!rst && done) done_cnt++;
    if (!rst && bus.cpu_write_enable) begin
      we_cnt++;
      check("we_addr", 32'(bus.cpu_addr), 32'(4'h9));
    end
  end

  task automatic write_word(input logic [3:0] a, input logic [11:0] w);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_word = w;
    @(negedge clk);
    prog_we   = 1'b0;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(done), 32'(1));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_opcode"}, 32'(bus.cpu_opcode), 32'(OP_IDLE));
    check({tag, "_busy"},   32'(busy), 32'(0));
    check({tag, "_we"},     32'(bus.cpu_write_enable), 32'(0));
    check({tag, "_addr"},   32'(bus.cpu_addr), 32'(0));
    check({tag, "_data"},   32'(bus.cpu_data), 32'(0));
    check({tag, "_done"},   32'(done), 32'(0));
    check({tag, "_rv"},     32'(result_valid), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int d0;
    rst = 1'b1; prog_we = 1'b0; prog_addr = 4'h0; prog_word = 12'h000;
    start = 1'b0; abort = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check_idle_outputs("rst");
    check("rst_pc", 32'(pc), 32'(0));
    check("rst_result", 32'(result), 32'(0));

    // Empty program: HALT fetched, done two cycles after start
    rv_cyc.delete();
    start_pulse();
    check("t1_busy_fetch", 32'(busy), 32'(1));
    check("t1_no_done_fetch", 32'(done), 32'(0));
    @(negedge clk);
    check("t1_done", 32'(done), 32'(1));
    check("t1_opcode", 32'(bus.cpu_opcode), 32'(OP_IDLE));
    @(negedge clk);
    check("t1_idle_busy", 32'(busy), 32'(0));
    check("t1_done_pulse", 32'(done), 32'(0));
    check("t1_no_result", 32'(rv_cyc.size()), 32'(0));

    // LOAD 5 then ADD 3: results 2 then 5, seven cycles apart
    write_word(4'd0, 12'h350);
    write_word(4'd1, 12'h003);
    sb.push_back('{res: 4'h2, pc: 4'h0});
    sb.push_back('{res: 4'h5, pc: 4'h1});
    rv_cyc.delete();
    start_pulse();
    @(negedge clk);
    check("t2_first_opcode", 32'(bus.cpu_opcode), 32'(OP_LOAD));
    check("t2_first_addr", 32'(bus.cpu_addr), 32'(4'h5));
    wait_done(30, "t2_done");
    check("t2_rv_count", 32'(rv_cyc.size()), 32'(2));
    check("t2_spacing", (rv_cyc.size() == 2) ? 32'(rv_cyc[1] - rv_cyc[0]) : 32'hFFFF_FFFF, 32'(7));
    check("t2_sb_empty", 32'(sb.size()), 32'(0));
    @(negedge clk);

    // STORE: write enable exactly during the three ISSUE cycles
    do_reset();
    write_word(4'd0, 12'h290);
    sb.push_back('{res: 4'h0, pc: 4'h0});
    we_cnt = 0;
    start_pulse();
    @(negedge clk);
    check("t3_we_issue", 32'(bus.cpu_write_enable), 32'(1));
    check("t3_opcode_issue", 32'(bus.cpu_opcode), 32'(OP_STORE));
    repeat (3) @(negedge clk);
    check("t3_we_wait", 32'(bus.cpu_write_enable), 32'(0));
    check("t3_opcode_wait", 32'(bus.cpu_opcode), 32'(OP_IDLE));
    check("t3_addr_held", 32'(bus.cpu_addr), 32'(4'h9));
    wait_done(20, "t3_done");
    check("t3_we_cycles", 32'(we_cnt), 32'(3));
    check("t3_sb_empty", 32'(sb.size()), 32'(0));
    @(negedge clk);

    // Full 16-word program: pc walks 0..15, no wrap
    do_reset();
    for (int i = 0; i < 16; i++) begin
      write_word(4'(i), 12'h001);
      sb.push_back('{res: 4'(i + 1), pc: 4'(i)});
    end
    rv_cyc.delete();
    start_pulse();
    wait_done(16 * 7 + 10, "t4_done");
    check("t4_pc_end", 32'(pc), 32'(15));
    check("t4_rv_count", 32'(rv_cyc.size()), 32'(16));
    check("t4_sb_empty", 32'(sb.size()), 32'(0));
    @(negedge clk);
    check("t4_pc_hold", 32'(pc), 32'(15));
    check("t4_idle", 32'(busy), 32'(0));

    // Abort in the second ISSUE cycle, then re-run from pc 0
    do_reset();
    write_word(4'd0, 12'h350);
    d0 = done_cnt;
    start_pulse();
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_idle_outputs("t5_abort");
    check("t5_pc", 32'(pc), 32'(0));
    check("t5_result_held", 32'(result), 32'(0));
    @(negedge clk);
    check("t5_no_done", 32'(done_cnt), 32'(d0));
    sb.push_back('{res: 4'h2, pc: 4'h0});
    start_pulse();
    wait_done(30, "t5_rerun_done");
    check("t5_sb_empty", 32'(sb.size()), 32'(0));
    @(negedge clk);

    // Program writes while busy are ignored
    do_reset();
    write_word(4'd0, 12'h350);
    write_word(4'd1, 12'h003);
    sb.push_back('{res: 4'h2, pc: 4'h0});
    sb.push_back('{res: 4'h5, pc: 4'h1});
    rv_cyc.delete();
    start_pulse();
    prog_we = 1'b1; prog_addr = 4'd1; prog_word = 12'hE00;
    repeat (3) @(negedge clk);
    prog_we = 1'b0;
    wait_done(30, "t6_done");
    check("t6_rv_count", 32'(rv_cyc.size()), 32'(2));
    check("t6_sb_empty", 32'(sb.size()), 32'(0));
    @(negedge clk);

    // Reset mid-ISSUE: outputs return to reset values, memory back to HALT
    do_reset();
    write_word(4'd0, 12'h350);
    start_pulse();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_outputs("t7_rst");
    check("t7_pc", 32'(pc), 32'(0));
    check("t7_result", 32'(result), 32'(0));
    rv_cyc.delete();
    start_pulse();
    @(negedge clk);
    check("t7_halt_done", 32'(done), 32'(1));
    check("t7_no_result", 32'(rv_cyc.size()), 32'(0));
    @(negedge clk);

    // start and prog_we together: FETCH sees the freshly written word
    prog_we = 1'b1; prog_addr = 4'd0; prog_word = 12'h350;
    start = 1'b1;
    sb.push_back('{res: 4'h2, pc: 4'h0});
    @(negedge clk);
    prog_we = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("t8_new_word_opcode", 32'(bus.cpu_opcode), 32'(OP_LOAD));
    wait_done(30, "t8_done");
    check("t8_sb_empty", 32'(sb.size()), 32'(0));
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
